usr_serdes_ctrl: RTL
====================

# usr_serdes_ctrl

Command-driven controller that sequences a universal shift register (hold / shift-right / shift-left / parallel-load) as a serializer/deserializer engine. A requester issues one command per transaction: parallel-load a word and shift it out serially, shift a word in from a serial line, or load only. The block generates the shift-register mode and serial-in controls, counts the bits, and returns the final register contents on a response handshake. It sits between a parallel word interface and a single-wire serial link.

## Interface
Parameters:
- WIDTH, 4, shift-register and data width (≥2)
- LENW, $clog2(WIDTH+1), width of bit-count field

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 TX_LSB, 01 RX, 10 TX_MSB, 11 LOAD
- cmd_data  in  WIDTH  word to load (TX/LOAD), ignored for RX
- cmd_len  in  LENW  bits to shift; 0 or >WIDTH means WIDTH
- sin  in  1  serial input, sampled in SHIFT/PAR (RX)
- sout  out  1  serial output
- sout_en  out  1  sout carries a valid bit this cycle
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  WIDTH  register contents at completion
- rsp_err  out  1  RX parity mismatch (0 when parity compiled out)
- usr_mode  out  2  current mode driven to the shift register (debug)

## Operation
- Mode encoding: 00 HOLD, 01 SHR (toward LSB, serial-in enters MSB), 10 SHL (serial-in enters LSB), 11 LOAD.
- States: IDLE, LOAD, SHIFT, PAR (only with parity), DONE.
- IDLE: cmd_ready=1, mode HOLD. Accept on cmd_valid&cmd_ready; latch op, effective len (n), data.
- LOAD (1 cycle): mode LOAD; loads cmd_data (TX_LSB, TX_MSB, LOAD) or all-zeros (RX). LOAD op goes to DONE; others go to SHIFT with counter=n.
- SHIFT (n cycles), sout_en=1 for TX only:
  - TX_LSB: mode SHR, serial-in 0, sout=q[0]; emits cmd_data[0] first.
  - TX_MSB: mode SHL, serial-in 0, sout=q[WIDTH-1]; emits cmd_data[WIDTH-1] first.
  - RX: mode SHL, serial-in=sin; first received bit ends in q[n-1], last in q[0]; upper bits stay 0.
  - Counter decrements each cycle; leave SHIFT on the cycle count reaches 1.
- DONE: rsp_valid=1, rsp_data=q, mode HOLD; hold until rsp_ready, then IDLE.
- sout=0 whenever sout_en=0.
- cmd_valid outside IDLE is ignored, not queued.
- Reset (any state, any cycle): state IDLE, counter 0, register 0, in-flight transaction discarded, no response issued. Reset values: cmd_ready=1, sout=0, sout_en=0, rsp_valid=0, rsp_data=0, rsp_err=0, usr_mode=00.

## Timing
- Accept at edge 0. LOAD during cycle 1, SHIFT during cycles 2..n+1, rsp_valid from cycle n+2 (n+3 with parity). LOAD op: rsp_valid in cycle 2.
- Bit k (0-based) of a TX appears on sout in cycle 2+k. RX samples sin at the end of cycles 2..n+1.
- With rsp_ready held high, DONE lasts 1 cycle and cmd_ready returns the following cycle. Back-to-back commands are spaced by n+3 cycles minimum.
- rsp_data and rsp_err are stable while rsp_valid=1.

## Configuration
- USR_SERDES_PARITY_EN defined: even parity over the n shifted bits, accumulated by a running XOR during SHIFT. One PAR cycle follows SHIFT, mode HOLD.
  - TX: sout=parity, sout_en=1.
  - RX: samples sin; rsp_err = sin ^ accumulated parity.
  - LOAD op skips PAR.
- Not defined: no PAR state, no accumulator, rsp_err tied 0.

## Structure
- Package usr_serdes_pkg: mode localparams (HOLD/SHR/SHL/LOAD), cmd_op encodings, state enum.
- One sub-module usr_core: WIDTH-bit universal shift register with clk, rst_n, mode, serial_in, parallel_in, q. It resets to 0 on rst_n low. The controller FSM, counter and parity accumulator live in the top.

## Test plan
- WIDTH=4, TX_LSB, data 4'b0110, len 0 -> sout 0,1,1,0 in cycles 2–5 with sout_en=1; rsp_valid cycle 6, rsp_data 0000.
- TX_MSB, data 4'b1010, len 2 -> sout 1,0; rsp_data 4'b1000.
- RX, len 4, sin 1,0,1,1 -> rsp_data 4'b1011. With parity and PAR-cycle sin=1: rsp_err=0; with sin=0: rsp_err=1.
- LOAD, data 4'b1100 -> rsp_valid cycle 2, rsp_data 1100, sout_en never high.
- rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, new cmd_valid ignored. Then rsp_ready=1 -> IDLE next cycle.
- rst_n low for one cycle mid-SHIFT -> next cycle IDLE, all outputs at reset values, no rsp_valid. A fresh command then completes normally.

Source files
------------

// File: rtl/usr_serdes_pkg.sv
// Shared modes, command encodings and FSM states for usr_serdes_ctrl.
// USR_SERDES_PARITY_EN adds the PAR state.
package usr_serdes_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] OP_TX_LSB = 2'b00;
  localparam logic [1:0] OP_RX     = 2'b01;
  localparam logic [1:0] OP_TX_MSB = 2'b10;
  localparam logic [1:0] OP_LOAD   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
`ifdef USR_SERDES_PARITY_EN
    S_PAR,
`endif
    S_DONE
  } state_t;

endpackage

// File: rtl/usr_core.sv
// Universal shift register: hold, shift right/left, parallel load.
// Shift right feeds serial_in into the MSB, shift left into the LSB.
module usr_core
  import usr_serdes_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      unique case (mode)
        MODE_SHR:  q <= {serial_in, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], serial_in};
        MODE_LOAD: q <= parallel_in;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_serdes_ctrl.sv
// Command-driven serializer/deserializer around usr_core.
// Optional even parity bit: define USR_SERDES_PARITY_EN.
module usr_serdes_ctrl
  import usr_serdes_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LENW  = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LENW-1:0]  cmd_len,
  input  logic             sin,
  output logic             sout,
  output logic             sout_en,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [1:0]       usr_mode
);

  localparam logic [LENW-1:0] WMAX = LENW'(WIDTH);
  localparam logic [LENW-1:0] ONE  = LENW'(1);

  state_t           state;
  state_t           nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  cnt;
  logic [LENW-1:0]  eff_len;
  logic [1:0]       mode;
  logic             ser_in;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] q;
  logic             is_rx;
  logic             bit_out;
  logic             sbit;
  logic             accept;

  usr_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .serial_in   (ser_in),
    .parallel_in (pin),
    .q           (q)
  );

  assign eff_len = (cmd_len == '0 || cmd_len > WMAX)
                 ? WMAX : cmd_len;
  assign is_rx   = (op_q == OP_RX);
  assign bit_out = (op_q == OP_TX_LSB) ? q[0] : q[WIDTH-1];
  assign sbit    = is_rx ? sin : bit_out;
  assign accept  = (state == S_IDLE) && cmd_valid;

`ifdef USR_SERDES_PARITY_EN
  logic par_q;
  logic err_q;
  localparam state_t AFTER_SHIFT = S_PAR;
`else
  localparam state_t AFTER_SHIFT = S_DONE;
`endif

  always_comb begin
    nxt       = state;
    mode      = MODE_HOLD;
    ser_in    = 1'b0;
    pin       = data_q;
    sout      = 1'b0;
    sout_en   = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) nxt = S_LOAD;
      end
      S_LOAD: begin
        mode = MODE_LOAD;
        pin  = is_rx ? '0 : data_q;
        nxt  = (op_q == OP_LOAD) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        mode    = (op_q == OP_TX_LSB) ? MODE_SHR : MODE_SHL;
        ser_in  = is_rx & sin;
        sout_en = !is_rx;
        sout    = !is_rx & bit_out;
        if (cnt == ONE) nxt = AFTER_SHIFT;
      end
`ifdef USR_SERDES_PARITY_EN
      S_PAR: begin
        sout_en = !is_rx;
        sout    = !is_rx & par_q;
        nxt     = S_DONE;
      end
`endif
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      data_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        len_q  <= eff_len;
      end
      if (state == S_LOAD) cnt <= len_q;
      if (state == S_SHIFT) cnt <= cnt - ONE;
    end
  end

`ifdef USR_SERDES_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        par_q <= 1'b0;
        err_q <= 1'b0;
      end
      if (state == S_SHIFT) par_q <= par_q ^ sbit;
      if (state == S_PAR && is_rx) err_q <= sin ^ par_q;
    end
  end
  assign rsp_err = rsp_valid & err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_data = rsp_valid ? q : '0;
  assign usr_mode = mode;

endmodule
